// File: rtl/decode_buffer_pkg.sv
// Shared types and constants for the instruction decode buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package decode_buffer_pkg;

   // Canonical RISC-V NOP (addi x0, x0, 0), driven on dec_instr while idle.
   localparam logic [31:0] nop_instr = 32'h0000_0013;

   // One buffered halfword plus the access-fault tag of the fetch word it came from.
   typedef struct packed {
      logic [15:0] data;
      logic        err;
   } hw_entry_t;

   // Head-of-buffer instruction as presented to decode.
   typedef struct packed {
      logic [31:0] instr;
      logic        compressed;
      logic        error;
   } dec_out_t;

   // A halfword starts a 16-bit instruction unless its low two bits are 2'b11.
   function automatic logic is_rvc(input logic [15:0] hw);
      return hw[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/decode_buffer_ram.sv
// Halfword storage for the decode buffer: ENTRIES x 17 bits, two write and two async read ports.
// Latency: writes land on the rising edge; reads are combinational.
// Backpressure: none; the caller decides when ports are enabled.
//
// Ports: clock/reset; we0/waddr0/wdata0 and we1/waddr1/wdata1 write ports;
//        raddr0/rdata0 and raddr1/rdata1 read ports.
// The data column carries no reset; only the err column is cleared by reset.
module decode_buffer_ram
   import decode_buffer_pkg::*;
#(
   parameter int ENTRIES = 8,
   parameter int AW      = $clog2(ENTRIES)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we0,
   input  logic [AW-1:0] waddr0,
   input  hw_entry_t     wdata0,
   input  logic          we1,
   input  logic [AW-1:0] waddr1,
   input  hw_entry_t     wdata1,
   input  logic [AW-1:0] raddr0,
   output hw_entry_t     rdata0,
   input  logic [AW-1:0] raddr1,
   output hw_entry_t     rdata1
);

   logic [15:0] data_q [ENTRIES];
   logic [15:0] data_d [ENTRIES];
   logic        err_q  [ENTRIES];
   logic        err_d  [ENTRIES];

   always_comb begin
      data_d = data_q;
      err_d  = err_q;
      if (we0) begin
         data_d[waddr0] = wdata0.data;
         err_d[waddr0]  = wdata0.err;
      end
      if (we1) begin
         data_d[waddr1] = wdata1.data;
         err_d[waddr1]  = wdata1.err;
      end
   end

   always_ff @(posedge clock) begin
      data_q <= data_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) err_q[i] <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign rdata0 = '{data: data_q[raddr0], err: err_q[raddr0]};
   assign rdata1 = '{data: data_q[raddr1], err: err_q[raddr1]};

endmodule

// File: rtl/decode_buffer.sv
// Fetch-word to instruction realignment buffer (RVC aware), 2*DEPTH halfword circular store.
// Latency: one cycle from push to dec_valid; head outputs are combinational from registered state.
// Backpressure: fetch_ready drops when fewer than two halfword slots are free or clear is high.
//
// Ports: clock, reset (async, active high), clear/clear_pc (flush + redirect),
//        fetch_valid/fetch_ready/fetch_rdata/fetch_error (word in),
//        dec_valid/dec_ready/dec_pc/dec_npc/dec_instr/dec_compressed/dec_error (instruction out).
module decode_buffer
   import decode_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic [XLEN-1:0] clear_pc,
   input  logic            fetch_valid,
   output logic            fetch_ready,
   input  logic [31:0]     fetch_rdata,
   input  logic            fetch_error,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_npc,
   output logic [31:0]     dec_instr,
   output logic            dec_compressed,
   output logic            dec_error
);

   localparam int ENTRIES = 2 * DEPTH;
   localparam int AW      = $clog2(ENTRIES);
   localparam int CW      = AW + 1;

   logic [AW-1:0]   rp_q, rp_d;
   logic [AW-1:0]   wp_q, wp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            odd_q, odd_d;
   logic [XLEN-1:0] pc_q, pc_d;

   hw_entry_t head0, head1;
   hw_entry_t wdata0, wdata1;
   logic      we0, we1;
   logic [AW-1:0] waddr0;
   logic      head_32;
   logic      push, pop;
   logic [CW-1:0] push_n, pop_n;
   logic [CW-1:0] free_slots;
   dec_out_t  dec_out;

   decode_buffer_ram #(.ENTRIES(ENTRIES)) u_ram (
      .clock  (clock),
      .reset  (reset),
      .we0    (we0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (wp_q + AW'(1)),
      .wdata1 (wdata1),
      .raddr0 (rp_q),
      .rdata0 (head0),
      .raddr1 (rp_q + AW'(1)),
      .rdata1 (head1)
   );

   assign head_32    = !is_rvc(head0.data);
   assign free_slots = CW'(ENTRIES) - cnt_q;
   assign fetch_ready = (free_slots >= CW'(2)) && !clear;
   assign dec_valid  = head_32 ? (cnt_q >= CW'(2)) : (cnt_q >= CW'(1));

   assign push   = fetch_valid && fetch_ready;
   assign pop    = dec_valid && dec_ready && !clear;
   // After a redirect to an odd halfword, the low half of the first word lies before the target.
   assign push_n = push ? (odd_q ? CW'(1) : CW'(2)) : CW'(0);
   assign pop_n  = pop ? (head_32 ? CW'(2) : CW'(1)) : CW'(0);

   always_comb begin
      we0    = 1'b0;
      we1    = 1'b0;
      waddr0 = wp_q;
      wdata0 = '{data: fetch_rdata[15:0], err: fetch_error};
      wdata1 = '{data: fetch_rdata[31:16], err: fetch_error};
      if (push) begin
         we0 = 1'b1;
         if (odd_q) begin
            wdata0 = '{data: fetch_rdata[31:16], err: fetch_error};
         end else begin
            we1 = 1'b1;
         end
      end
   end

   always_comb begin
      dec_out = '{instr: nop_instr, compressed: 1'b0, error: 1'b0};
      if (dec_valid) begin
         dec_out.compressed = !head_32;
         dec_out.instr      = head_32 ? {head1.data, head0.data} : {16'h0000, head0.data};
         dec_out.error      = head0.err | (head_32 & head1.err);
      end
   end

   assign dec_instr      = dec_out.instr;
   assign dec_compressed = dec_out.compressed;
   assign dec_error      = dec_out.error;
   assign dec_pc         = pc_q;
   assign dec_npc        = pc_q + (head_32 ? XLEN'(4) : XLEN'(2));

   always_comb begin
      rp_d  = rp_q;
      wp_d  = wp_q;
      cnt_d = cnt_q;
      odd_d = odd_q;
      pc_d  = pc_q;
      if (clear) begin
         rp_d  = '0;
         wp_d  = '0;
         cnt_d = '0;
         odd_d = clear_pc[1];
         pc_d  = clear_pc;
      end else begin
         rp_d  = rp_q + pop_n[AW-1:0];
         wp_d  = wp_q + push_n[AW-1:0];
         cnt_d = cnt_q + push_n - pop_n;
         if (push) odd_d = 1'b0;
         if (pop)  pc_d  = dec_npc;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rp_q  <= '0;
         wp_q  <= '0;
         cnt_q <= '0;
         odd_q <= 1'b0;
         pc_q  <= '0;
      end else begin
         rp_q  <= rp_d;
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
         odd_q <= odd_d;
         pc_q  <= pc_d;
      end
   end

endmodule

// File: tb/tb_decode_buffer.sv
// Directed bench for decode_buffer (DEPTH=4, XLEN=32).
// Latency: inputs change 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpressure: exercised by filling the buffer with dec_ready low.
module tb_decode_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic        clear;
   logic [31:0] clear_pc;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_rdata;
   logic        fetch_error;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [31:0] dec_npc;
   logic [31:0] dec_instr;
   logic        dec_compressed;
   logic        dec_error;

   int checks   = 0;
   int failures = 0;

   decode_buffer #(.DEPTH(4), .XLEN(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .clear          (clear),
      .clear_pc       (clear_pc),
      .fetch_valid    (fetch_valid),
      .fetch_ready    (fetch_ready),
      .fetch_rdata    (fetch_rdata),
      .fetch_error    (fetch_error),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_pc         (dec_pc),
      .dec_npc        (dec_npc),
      .dec_instr      (dec_instr),
      .dec_compressed (dec_compressed),
      .dec_error      (dec_error)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_clear(input logic [31:0] pc);
      clear    = 1'b1;
      clear_pc = pc;
      tick();
      clear = 1'b0;
      #1;
   endtask

   task automatic push(input logic [31:0] word, input logic err);
      fetch_valid = 1'b1;
      fetch_rdata = word;
      fetch_error = err;
      tick();
      fetch_valid = 1'b0;
      fetch_error = 1'b0;
      #1;
   endtask

   task automatic pop();
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%0h exp=0", dec_valid); end
      checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL reset_fetch_ready got=%0h exp=1", fetch_ready); end
      checks++; if (dec_pc !== 32'h0) begin failures++; $display("FAIL reset_dec_pc got=%0h exp=0", dec_pc); end
      #10;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic32();
      do_clear(32'h100);
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL b32_empty_valid got=%0h exp=0", dec_valid); end
      push(32'h00A0_0093, 1'b0);
      checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL b32_valid got=%0h exp=1", dec_valid); end
      checks++; if (dec_pc !== 32'h100) begin failures++; $display("FAIL b32_pc got=%0h exp=100", dec_pc); end
      checks++; if (dec_npc !== 32'h104) begin failures++; $display("FAIL b32_npc got=%0h exp=104", dec_npc); end
      checks++; if (dec_compressed !== 1'b0) begin failures++; $display("FAIL b32_compressed got=%0h exp=0", dec_compressed); end
      checks++; if (dec_instr !== 32'h00A0_0093) begin failures++; $display("FAIL b32_instr got=%0h exp=00a00093", dec_instr); end
      pop();
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL b32_after_pop_valid got=%0h exp=0", dec_valid); end
      checks++; if (dec_pc !== 32'h104) begin failures++; $display("FAIL b32_after_pop_pc got=%0h exp=104", dec_pc); end
   endtask

   task automatic test_compressed();
      do_clear(32'h100);
      push(32'h4501_4501, 1'b0);
      dec_ready = 1'b1;
      #1;
      checks++; if (dec_instr !== 32'h0000_4501) begin failures++; $display("FAIL c16_first_instr got=%0h exp=4501", dec_instr); end
      checks++; if (dec_pc !== 32'h100 || dec_npc !== 32'h102) begin failures++; $display("FAIL c16_first_pc got=%0h/%0h exp=100/102", dec_pc, dec_npc); end
      checks++; if (dec_compressed !== 1'b1) begin failures++; $display("FAIL c16_compressed got=%0h exp=1", dec_compressed); end
      tick();
      checks++; if (dec_valid !== 1'b1 || dec_instr !== 32'h0000_4501) begin failures++; $display("FAIL c16_second got=%0h/%0h exp=1/4501", dec_valid, dec_instr); end
      checks++; if (dec_pc !== 32'h102) begin failures++; $display("FAIL c16_second_pc got=%0h exp=102", dec_pc); end
      tick();
      dec_ready = 1'b0;
      #1;
      checks++; if (dec_valid !== 1'b0 || dec_pc !== 32'h104) begin failures++; $display("FAIL c16_drained got=%0h/%0h exp=0/104", dec_valid, dec_pc); end
   endtask

   task automatic test_odd_start();
      do_clear(32'h102);
      push(32'h0093_4501, 1'b0);
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL odd_half_valid got=%0h exp=0", dec_valid); end
      push(32'h0000_00A0, 1'b0);
      checks++; if (dec_valid !== 1'b1 || dec_instr !== 32'h00A0_0093) begin failures++; $display("FAIL odd_instr got=%0h/%0h exp=1/00a00093", dec_valid, dec_instr); end
      checks++; if (dec_pc !== 32'h102 || dec_npc !== 32'h106) begin failures++; $display("FAIL odd_pc got=%0h/%0h exp=102/106", dec_pc, dec_npc); end
      checks++; if (dut.cnt_q !== 4'd3) begin failures++; $display("FAIL odd_count got=%0d exp=3", dut.cnt_q); end
   endtask

   task automatic test_full();
      do_clear(32'h0);
      for (int i = 0; i < 4; i++) push(32'h00A0_0093, 1'b0);
      checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0h exp=0", fetch_ready); end
      checks++; if (dut.cnt_q !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", dut.cnt_q); end
      push(32'h1111_1111, 1'b0);
      checks++; if (dut.cnt_q !== 4'd8) begin failures++; $display("FAIL full_drop_count got=%0d exp=8", dut.cnt_q); end
      pop();
      checks++; if (dut.cnt_q !== 4'd6 || fetch_ready !== 1'b1) begin failures++; $display("FAIL full_pop got=%0d/%0h exp=6/1", dut.cnt_q, fetch_ready); end
      checks++; if (dec_pc !== 32'h4) begin failures++; $display("FAIL full_pop_pc got=%0h exp=4", dec_pc); end
      // Write pointer wraps to slot 0 here; the head keeps draining around the wrap.
      push(32'h4501_4501, 1'b0);
      for (int i = 0; i < 3; i++) pop();
      checks++; if (dec_valid !== 1'b1 || dec_instr !== 32'h0000_4501) begin failures++; $display("FAIL wrap_head got=%0h/%0h exp=1/4501", dec_valid, dec_instr); end
      checks++; if (dec_pc !== 32'h10) begin failures++; $display("FAIL wrap_pc got=%0h exp=10", dec_pc); end
   endtask

   task automatic test_error();
      do_clear(32'h0);
      push(32'h0093_4501, 1'b1);
      push(32'h4501_00A0, 1'b0);
      checks++; if (dec_error !== 1'b1 || dec_compressed !== 1'b1) begin failures++; $display("FAIL err_first got=%0h/%0h exp=1/1", dec_error, dec_compressed); end
      pop();
      checks++; if (dec_instr !== 32'h00A0_0093 || dec_error !== 1'b1) begin failures++; $display("FAIL err_straddle got=%0h/%0h exp=00a00093/1", dec_instr, dec_error); end
      pop();
      checks++; if (dec_pc !== 32'h6 || dec_error !== 1'b0 || dec_instr !== 32'h0000_4501) begin failures++; $display("FAIL err_clean got=%0h/%0h/%0h exp=6/0/4501", dec_pc, dec_error, dec_instr); end
   endtask

   task automatic test_clear_and_reset();
      do_clear(32'h2);
      for (int i = 0; i < 3; i++) push(32'h4501_4501, 1'b0);
      checks++; if (dut.cnt_q !== 4'd5) begin failures++; $display("FAIL clr_prefill got=%0d exp=5", dut.cnt_q); end
      clear       = 1'b1;
      clear_pc    = 32'h200;
      fetch_valid = 1'b1;
      fetch_rdata = 32'h00A0_0093;
      #1;
      checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL clr_ready got=%0h exp=0", fetch_ready); end
      tick();
      clear       = 1'b0;
      fetch_valid = 1'b0;
      #1;
      checks++; if (dut.cnt_q !== 4'd0 || dec_valid !== 1'b0) begin failures++; $display("FAIL clr_state got=%0d/%0h exp=0/0", dut.cnt_q, dec_valid); end
      checks++; if (dec_pc !== 32'h200) begin failures++; $display("FAIL clr_pc got=%0h exp=200", dec_pc); end
      push(32'h4501_4501, 1'b0);
      checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%0h exp=1", dec_valid); end
      #1;
      reset = 1'b1;
      #1;
      checks++; if (dec_valid !== 1'b0 || fetch_ready !== 1'b1) begin failures++; $display("FAIL rst_async got=%0h/%0h exp=0/1", dec_valid, fetch_ready); end
      checks++; if (dec_pc !== 32'h0) begin failures++; $display("FAIL rst_async_pc got=%0h exp=0", dec_pc); end
      #2;
      reset = 1'b0;
      tick();
      checks++; if (dec_valid !== 1'b0 || dut.cnt_q !== 4'd0) begin failures++; $display("FAIL rst_after got=%0h/%0d exp=0/0", dec_valid, dut.cnt_q); end
   endtask

   initial begin
      reset       = 1'b1;
      clear       = 1'b0;
      clear_pc    = '0;
      fetch_valid = 1'b0;
      fetch_rdata = '0;
      fetch_error = 1'b0;
      dec_ready   = 1'b0;
      test_reset();
      test_basic32();
      test_compressed();
      test_odd_start();
      test_full();
      test_error();
      test_clear_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
